seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers the hex word shown on a scanned 4-digit 7-segment display.
// Define SEGDEC_DP_EN to also decode the decimal points from SEG[7].
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        R,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEG,
    output logic [15:0] dat,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        frame,
    output logic        err
);

`ifdef SEGDEC_DP_EN
    localparam int W = 12;
`else
    localparam int W = 11;
`endif
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [W-1:0]  pins, s1, s2, prv;
    logic [SW-1:0] scnt;
    logic [TW-1:0] tcnt;
    logic [15:0]   sh_dat;
    logic [3:0]    sh_blank, seen, seen_d, an_s, g_nib;
    logic [6:0]    gl;
    logic [1:0]    dig;
    logic          stable, strobe, an_one, an_idle, g_ok, g_blank;
    logic          cap, bad, expire;

    assign pins   = {AN, SEG[W-5:0]};
    assign an_s   = s2[W-1 -: 4];
    assign gl     = ~s2[6:0];
    assign stable = (s2 == prv);
    assign strobe = stable && (scnt == SW'(SETTLE - 1));

    always_comb begin
        g_ok    = 1'b1;
        g_blank = 1'b0;
        g_nib   = 4'h0;
        case (gl)
            7'h3F: g_nib = 4'h0;
            7'h06: g_nib = 4'h1;
            7'h5B: g_nib = 4'h2;
            7'h4F: g_nib = 4'h3;
            7'h66: g_nib = 4'h4;
            7'h6D: g_nib = 4'h5;
            7'h7D: g_nib = 4'h6;
            7'h07: g_nib = 4'h7;
            7'h7F: g_nib = 4'h8;
            7'h6F: g_nib = 4'h9;
            7'h77: g_nib = 4'hA;
            7'h7C: g_nib = 4'hB;
            7'h39: g_nib = 4'hC;
            7'h5E: g_nib = 4'hD;
            7'h79: g_nib = 4'hE;
            7'h71: g_nib = 4'hF;
            7'h00: g_blank = 1'b1;
            default: g_ok = 1'b0;
        endcase
    end

    always_comb begin
        an_one  = 1'b1;
        an_idle = 1'b0;
        dig     = 2'd0;
        case (an_s)
            4'b1110: dig = 2'd0;
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            4'b1111: begin
                an_one  = 1'b0;
                an_idle = 1'b1;
            end
            default: an_one = 1'b0;
        endcase
    end

    assign cap    = strobe && an_one && g_ok;
    assign bad    = strobe && !an_idle && !(an_one && g_ok);
    assign expire = !cap && (tcnt == TW'(TIMEOUT - 1));

    // A completed or timed-out mask clears before this cycle's capture lands
    always_comb begin
        seen_d = seen;
        if (seen == 4'hF || expire)
            seen_d = 4'h0;
        if (cap)
            seen_d[dig] = 1'b1;
    end

`ifdef SEGDEC_DP_EN
    logic [3:0] sh_dp;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            sh_dp <= '0;
            dp    <= '0;
        end else begin
            if (cap)
                sh_dp[dig] <= ~s2[7];
            if (seen == 4'hF)
                dp <= sh_dp;
        end
    end
`else
    logic unused_dp;
    assign unused_dp = SEG[7];
    assign dp = 4'b0000;
`endif

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            s1       <= '1;
            s2       <= '1;
            prv      <= '1;
            scnt     <= '0;
            tcnt     <= '0;
            seen     <= '0;
            sh_dat   <= '0;
            sh_blank <= '0;
            dat      <= '0;
            blank    <= '0;
            valid    <= 1'b0;
            frame    <= 1'b0;
            err      <= 1'b0;
        end else begin
            s1  <= pins;
            s2  <= s1;
            prv <= s2;
            if (!stable)
                scnt <= '0;
            else if (scnt != SW'(SETTLE))
                scnt <= scnt + SW'(1);
            if (cap)
                tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT))
                tcnt <= tcnt + TW'(1);
            if (cap) begin
                sh_dat[{dig, 2'b00} +: 4] <= g_nib;
                sh_blank[dig]             <= g_blank;
            end
            seen  <= seen_d;
            frame <= (seen == 4'hF);
            if (seen == 4'hF) begin
                dat   <= sh_dat;
                blank <= sh_blank;
                valid <= 1'b1;
            end else if (expire) begin
                valid <= 1'b0;
            end
            if (bad)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random scan
// traffic scored against a hold-level model of the display protocol.
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        R;
    logic [3:0]  AN;
    logic [7:0]  SEG;
    logic [15:0] dat;
    logic [3:0]  dp, blank;
    logic        valid, frame, err;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .R(R), .AN(AN), .SEG(SEG), .dat(dat), .dp(dp),
        .blank(blank), .valid(valid), .frame(frame), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [7:0] seg;
    } ev_t;

    ev_t         pq[$];
    logic [6:0]  glyph [16];
    int          checks, errors, e;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_bl, m_dpb, m_seen, m_dp, m_blank, f_dp, f_blank;
    logic [15:0] m_dat, f_dat;
    logic        m_valid, m_err, m_frame, pv;
    int          last_cap, frame_t, mframes, nframes, frame_e, vfall_e;
    logic [10:0] cur_key;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_bl = 0; m_dpb = 0; m_seen = 0; m_dp = 0; m_blank = 0;
        m_dat = 0; m_valid = 0; m_err = 0; m_frame = 0;
        frame_t = -1; last_cap = e; cur_key = {4'hF, 7'h7F};
        pq.delete();
    endfunction

    // One stable hold seen by the decoder: classify AN, look up the glyph
    function automatic void apply_ev(input ev_t ev);
        int zeros, d, n;
        logic [6:0] g;
        zeros = $countones(~ev.an);
        if (zeros == 0) return;
        if (zeros > 1) begin m_err = 1; return; end
        d = 0;
        for (int i = 0; i < 4; i++) if (!ev.an[i]) d = i;
        g = ~ev.seg[6:0];
        n = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == g) n = i;
        if (g != 7'h00 && n < 0) begin m_err = 1; return; end
        m_nib[d] = (n < 0) ? 4'h0 : 4'(n);
        m_bl[d] = (g == 7'h00);
`ifdef SEGDEC_DP_EN
        m_dpb[d] = !ev.seg[7];
`endif
        m_seen[d] = 1'b1;
        last_cap = e;
        if (m_seen == 4'hF) begin
            for (int i = 0; i < 4; i++) f_dat[4*i +: 4] = m_nib[i];
            f_dp = m_dpb; f_blank = m_bl;
            frame_t = e + 1; m_seen = 0;
        end
    endfunction

    function automatic void model_step();
        ev_t ev;
        m_frame = 0;
        while (pq.size() > 0 && pq[0].t == e) begin
            ev = pq.pop_front();
            apply_ev(ev);
        end
        if (frame_t == e) begin
            m_frame = 1; m_dat = f_dat; m_dp = f_dp; m_blank = f_blank;
            m_valid = 1; mframes++;
        end
        if (e - last_cap == TIMEOUT) begin m_valid = 0; m_seen = 0; end
    endfunction

    // Drive one AN/SEG pattern for h cycles, scoring every cycle
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int h);
        ev_t ev;
        AN = an; SEG = seg; cur_key = {an, seg[6:0]};
        if (h >= SETTLE + 1) begin
            ev.t = e + SETTLE + 3; ev.an = an; ev.seg = seg;
            pq.push_back(ev);
        end
        repeat (h) begin
            @(negedge clk);
            e++;
            model_step();
            checks++;
            if (frame !== m_frame) begin errors++; $display("FAIL mon_frame e=%0d got %b want %b", e, frame, m_frame); end
            checks++;
            if (valid !== m_valid) begin errors++; $display("FAIL mon_valid e=%0d got %b want %b", e, valid, m_valid); end
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL mon_err e=%0d got %b want %b", e, err, m_err); end
            checks++;
            if (dat !== m_dat) begin errors++; $display("FAIL mon_dat e=%0d got %h want %h", e, dat, m_dat); end
            checks++;
            if (dp !== m_dp) begin errors++; $display("FAIL mon_dp e=%0d got %b want %b", e, dp, m_dp); end
            checks++;
            if (blank !== m_blank) begin errors++; $display("FAIL mon_blank e=%0d got %b want %b", e, blank, m_blank); end
            if (frame === 1'b1) begin nframes++; frame_e = e; end
            if (pv === 1'b1 && valid === 1'b0) vfall_e = e;
            pv = valid;
        end
    endtask

    task automatic pulse_reset();
        R = 1; AN = 4'hF; SEG = 8'hFF;
        repeat (3) begin @(negedge clk); e++; end
        R = 0;
        model_reset();
        pv = 0;
    endtask

    task automatic good_frame();
        hold(4'hE, 8'hB0, 8); hold(4'hD, 8'h88, 8);
        hold(4'hB, 8'hC0, 8);
    endtask

    task automatic test_reset();
        nframes = 0;
        good_frame(); hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 4);
        checks++;
        if (dat !== 16'hF0A3) begin errors++; $display("FAIL pre_reset_dat got %h want F0A3", dat); end
        hold(4'hE, 8'hB0, 8); hold(4'hD, 8'h88, 8); hold(4'hE, 8'hFE, 8); hold(4'hB, 8'hC0, 3);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got %b want 1", err); end
        pulse_reset();
        checks++;
        if (dat !== 16'h0) begin errors++; $display("FAIL rst_dat got %h want 0000", dat); end
        checks++;
        if (dp !== 4'h0 || blank !== 4'h0) begin errors++; $display("FAIL rst_dp_blank got %b %b want 0000 0000", dp, blank); end
        checks++;
        if (valid !== 1'b0 || frame !== 1'b0) begin errors++; $display("FAIL rst_valid_frame got %b %b want 0 0", valid, frame); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        nframes = 0;
        hold(4'hB, 8'hC0, 8); hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 105);
        checks++;
        if (nframes !== 0) begin errors++; $display("FAIL rst_partial got %0d frames want 0", nframes); end
    endtask

    task automatic test_good_frame();
        int td;
        nframes = 0;
        good_frame();
        td = e;
        hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 10);
        checks++;
        if (nframes !== 1) begin errors++; $display("FAIL good_count got %0d want 1", nframes); end
        checks++;
        if (frame_e !== td + SETTLE + 4) begin errors++; $display("FAIL good_latency got %0d want %0d", frame_e, td + SETTLE + 4); end
        checks++;
        if (dat !== 16'hF0A3) begin errors++; $display("FAIL good_dat got %h want F0A3", dat); end
        checks++;
        if (valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL good_flags got v%b e%b want v1 e0", valid, err); end
    endtask

    task automatic test_glitch();
        nframes = 0;
        hold(4'hE, 8'hF9, 3); hold(4'hF, 8'hFF, 10);
        hold(4'hD, 8'h88, 8); hold(4'hB, 8'hC0, 8); hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 10);
        checks++;
        if (nframes !== 0) begin errors++; $display("FAIL glitch_frames got %0d want 0", nframes); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL glitch_err got %b want 0", err); end
        hold(4'hE, 8'hF9, 8); hold(4'hF, 8'hFF, 10);
        checks++;
        if (nframes !== 1 || dat !== 16'hF0A1) begin errors++; $display("FAIL glitch_fill got %0d %h want 1 F0A1", nframes, dat); end
    endtask

    task automatic test_dp_blank();
        logic [3:0] exp_dp;
`ifdef SEGDEC_DP_EN
        exp_dp = 4'b0100;
`else
        exp_dp = 4'b0000;
`endif
        nframes = 0;
        hold(4'hE, 8'hB0, 8); hold(4'hD, 8'hFF, 8); hold(4'hB, 8'h30, 8);
        hold(4'h7, 8'hC0, 8); hold(4'hF, 8'hFF, 10);
        checks++;
        if (nframes !== 1 || dat !== 16'h0303) begin errors++; $display("FAIL dpb_dat got %0d %h want 1 0303", nframes, dat); end
        checks++;
        if (blank !== 4'b0010) begin errors++; $display("FAIL dpb_blank got %b want 0010", blank); end
        checks++;
        if (dp !== exp_dp) begin errors++; $display("FAIL dpb_dp got %b want %b", dp, exp_dp); end
    endtask

    task automatic test_invalid();
        nframes = 0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL inv_pre got %b want 0", err); end
        hold(4'hE, 8'hFE, 8);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inv_glyph got %b want 1", err); end
        hold(4'hC, 8'hB0, 8);
        checks++;
        if (err !== 1'b1 || nframes !== 0) begin errors++; $display("FAIL inv_an got %b %0d want 1 0", err, nframes); end
        good_frame(); hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 10);
        checks++;
        if (nframes !== 1 || err !== 1'b1) begin errors++; $display("FAIL inv_after got %0d %b want 1 1", nframes, err); end
    endtask

    task automatic test_timeout();
        int td;
        good_frame();
        td = e;
        vfall_e = -1;
        hold(4'h7, 8'h8E, 8); hold(4'hF, 8'hFF, 120);
        checks++;
        if (vfall_e !== td + SETTLE + 3 + TIMEOUT) begin errors++; $display("FAIL to_fall got %0d want %0d", vfall_e, td + SETTLE + 3 + TIMEOUT); end
        checks++;
        if (valid !== 1'b0 || dat !== 16'hF0A3) begin errors++; $display("FAIL to_hold got %b %h want 0 F0A3", valid, dat); end
    endtask

    task automatic test_random();
        pulse_reset();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rnd_rst_err got %b want 0", err); end
        nframes = 0; mframes = 0;
        for (int k = 0; k < 250; k++) begin
            logic [3:0] an;
            logic [7:0] seg;
            int h, r;
            do begin
                r = $urandom_range(0, 19);
                if (r < 12) an = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
                else if (r < 18) an = 4'hF;
                else an = 4'($urandom_range(0, 15));
                r = $urandom_range(0, 9);
                if (r < 7) seg = {1'($urandom_range(0, 1)), ~glyph[$urandom_range(0, 15)]};
                else if (r < 9) seg = {1'($urandom_range(0, 1)), 7'h7F};
                else seg = 8'($urandom);
                h = $urandom_range(2, 10);
            end while ({an, seg[6:0]} == cur_key);
            hold(an, seg, h);
        end
        hold(4'hF, 8'hFF, 20);
        checks++;
        if (nframes !== mframes) begin errors++; $display("FAIL rnd_frames got %0d want %0d", nframes, mframes); end
    endtask

    initial begin
        R = 1; AN = 4'hF; SEG = 8'hFF;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        checks = 0; errors = 0; e = 0; pv = 0;
        nframes = 0; mframes = 0; frame_e = -1; vfall_e = -1;
        @(negedge clk);
        R = 0;
        model_reset();
        test_reset();
        test_good_frame();
        test_glitch();
        test_dp_blank();
        test_invalid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
